// File: rtl/score_controller_if.sv
// Bus between the pong game-flow sequencer and its neighbours
// (frame sync, start button, point pulses, scoreboard and ball control).
interface score_controller_if;
  logic       vsync;
  logic       start;
  logic       player_point;
  logic       ai_point;
  logic [3:0] player_score;
  logic [3:0] ai_score;
  logic       serve;
  logic       serve_dir;
  logic       ball_enable;
  logic       blank_player;
  logic       blank_ai;
  logic       game_over;
  logic       winner;

  // Environment side: drives sync, button and point pulses.
  modport master (
    output vsync, start, player_point, ai_point,
    input  player_score, ai_score, serve, serve_dir, ball_enable,
           blank_player, blank_ai, game_over, winner
  );

  // Sequencer side.
  modport slave (
    input  vsync, start, player_point, ai_point,
    output player_score, ai_score, serve, serve_dir, ball_enable,
           blank_player, blank_ai, game_over, winner
  );
endinterface

// File: rtl/score_controller.sv
// Pong game-flow sequencer: owns the scores, times the serve in frames,
// enables ball motion and flashes the scoring/winning digit.
module score_controller #(
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned FLASH_FRAMES = 8
) (
  input  logic               VGA_CLK,
  input  logic               resetn,
  score_controller_if.slave  bus
);

  localparam int unsigned SERVE_W = $clog2(SERVE_FRAMES + 1);
  localparam int unsigned FLASH_W = $clog2(FLASH_FRAMES + 1);

  typedef enum logic [1:0] {S_IDLE, S_SERVE_WAIT, S_PLAY, S_GAME_OVER} state_e;
  typedef enum logic [1:0] {T_NONE, T_PLAYER, T_AI} target_e;

  state_e             state_q, state_d;
  target_e            target_q, target_d;
  logic [3:0]         player_score_q, player_score_d;
  logic [3:0]         ai_score_q, ai_score_d;
  logic [SERVE_W-1:0] serve_cnt_q, serve_cnt_d;
  logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
  logic               phase_q, phase_d;
  logic               vsync_q;
  logic               serve_q, serve_d;
  logic               serve_dir_q, serve_dir_d;
  logic               ball_enable_q, ball_enable_d;
  logic               blank_player_q, blank_player_d;
  logic               blank_ai_q, blank_ai_d;
  logic               game_over_q, game_over_d;
  logic               winner_q, winner_d;
  logic               tick_c;
  logic [3:0]         player_inc_c, ai_inc_c;

  assign tick_c       = bus.vsync & ~vsync_q;
  assign player_inc_c = player_score_q + 4'd1;
  assign ai_inc_c     = ai_score_q + 4'd1;

  // State and output registers.
  always_ff @(posedge VGA_CLK or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      target_q       <= T_NONE;
      player_score_q <= '0;
      ai_score_q     <= '0;
      serve_cnt_q    <= '0;
      flash_cnt_q    <= '0;
      phase_q        <= 1'b0;
      vsync_q        <= 1'b0;
      serve_q        <= 1'b0;
      serve_dir_q    <= 1'b0;
      ball_enable_q  <= 1'b0;
      blank_player_q <= 1'b0;
      blank_ai_q     <= 1'b0;
      game_over_q    <= 1'b0;
      winner_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      target_q       <= target_d;
      player_score_q <= player_score_d;
      ai_score_q     <= ai_score_d;
      serve_cnt_q    <= serve_cnt_d;
      flash_cnt_q    <= flash_cnt_d;
      phase_q        <= phase_d;
      vsync_q        <= bus.vsync;
      serve_q        <= serve_d;
      serve_dir_q    <= serve_dir_d;
      ball_enable_q  <= ball_enable_d;
      blank_player_q <= blank_player_d;
      blank_ai_q     <= blank_ai_d;
      game_over_q    <= game_over_d;
      winner_q       <= winner_d;
    end
  end

  // Next-state and next-output logic; outputs derive from next-state values.
  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    player_score_d = player_score_q;
    ai_score_d     = ai_score_q;
    serve_cnt_d    = serve_cnt_q;
    flash_cnt_d    = flash_cnt_q;
    phase_d        = phase_q;
    serve_d        = 1'b0;
    serve_dir_d    = serve_dir_q;
    winner_d       = winner_q;

    // Flash timebase, advanced on frame ticks while a digit is flashing.
    if (tick_c && (state_q == S_GAME_OVER ||
                   (state_q == S_SERVE_WAIT && target_q != T_NONE))) begin
      if (flash_cnt_q <= FLASH_W'(1)) begin
        phase_d     = ~phase_q;
        flash_cnt_d = FLASH_W'(FLASH_FRAMES);
      end else begin
        flash_cnt_d = flash_cnt_q - FLASH_W'(1);
      end
    end

    case (state_q)
      S_IDLE, S_GAME_OVER: begin
        if (bus.start) begin
          state_d        = S_SERVE_WAIT;
          target_d       = T_NONE;
          player_score_d = '0;
          ai_score_d     = '0;
          serve_dir_d    = 1'b0;
          winner_d       = 1'b0;
          serve_cnt_d    = SERVE_W'(SERVE_FRAMES);
          phase_d        = 1'b0;
        end
      end
      S_SERVE_WAIT: begin
        if (tick_c) begin
          if (serve_cnt_q == SERVE_W'(1)) begin
            state_d     = S_PLAY;
            serve_d     = 1'b1;
            phase_d     = 1'b0;
            serve_cnt_d = '0;
          end else begin
            serve_cnt_d = serve_cnt_q - SERVE_W'(1);
          end
        end
      end
      S_PLAY: begin
        if (bus.player_point || bus.ai_point) begin
          state_d     = S_SERVE_WAIT;
          serve_cnt_d = SERVE_W'(SERVE_FRAMES);
          flash_cnt_d = FLASH_W'(FLASH_FRAMES);
          phase_d     = 1'b0;
          if (bus.player_point && bus.ai_point) begin
            target_d = T_NONE;
          end else if (bus.player_point) begin
            player_score_d = player_inc_c;
            target_d       = T_PLAYER;
            serve_dir_d    = 1'b1;
            if (player_inc_c == 4'(WIN_SCORE)) begin
              state_d  = S_GAME_OVER;
              winner_d = 1'b1;
            end
          end else begin
            ai_score_d  = ai_inc_c;
            target_d    = T_AI;
            serve_dir_d = 1'b0;
            if (ai_inc_c == 4'(WIN_SCORE)) begin
              state_d  = S_GAME_OVER;
              winner_d = 1'b0;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    ball_enable_d  = (state_d == S_PLAY);
    game_over_d    = (state_d == S_GAME_OVER);
    blank_player_d = phase_d &
                     (((state_d == S_SERVE_WAIT) && (target_d == T_PLAYER)) ||
                      ((state_d == S_GAME_OVER) && winner_d));
    blank_ai_d     = phase_d &
                     (((state_d == S_SERVE_WAIT) && (target_d == T_AI)) ||
                      ((state_d == S_GAME_OVER) && !winner_d));
  end

  assign bus.player_score = player_score_q;
  assign bus.ai_score     = ai_score_q;
  assign bus.serve        = serve_q;
  assign bus.serve_dir    = serve_dir_q;
  assign bus.ball_enable  = ball_enable_q;
  assign bus.blank_player = blank_player_q;
  assign bus.blank_ai     = blank_ai_q;
  assign bus.game_over    = game_over_q;
  assign bus.winner       = winner_q;

endmodule

// File: tb/tb_score_controller.sv
// Directed bench for score_controller (WIN=3, SERVE=3, FLASH=2).
module tb_score_controller;

  logic clk;
  logic resetn;
  int   n_tests;
  int   n_fail;
  logic snap_serve, snap_ben, snap_bp, snap_ba;

  score_controller_if bus ();

  score_controller #(
    .WIN_SCORE    (3),
    .SERVE_FRAMES (3),
    .FLASH_FRAMES (2)
  ) dut (
    .VGA_CLK (clk),
    .resetn  (resetn),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; return 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One vsync rising edge; snapshot outputs right after the tick edge.
  task automatic frame_tick();
    bus.vsync = 1'b1;
    step();
    snap_serve = bus.serve;
    snap_ben   = bus.ball_enable;
    snap_bp    = bus.blank_player;
    snap_ba    = bus.blank_ai;
    bus.vsync = 1'b0;
    step();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic pulse_points(input logic p, input logic a);
    bus.player_point = p;
    bus.ai_point     = a;
    step();
    bus.player_point = 1'b0;
    bus.ai_point     = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ps"},  8'(bus.player_score), 8'd0);
    chk({tag, ".as"},  8'(bus.ai_score), 8'd0);
    chk({tag, ".ctl"}, {1'b0, bus.serve, bus.serve_dir, bus.ball_enable,
                        bus.blank_player, bus.blank_ai, bus.game_over, bus.winner}, 8'd0);
  endtask

  // Three ticks: no serve on the first two, serve pulse of one cycle on the third.
  task automatic serve_sequence(input string tag);
    frame_tick();
    chk({tag, ".t1_serve"}, 8'(snap_serve), 8'd0);
    frame_tick();
    chk({tag, ".t2_serve"}, 8'(snap_serve), 8'd0);
    frame_tick();
    chk({tag, ".t3_serve"}, 8'(snap_serve), 8'd1);
    chk({tag, ".t3_ben"},   8'(snap_ben), 8'd1);
    chk({tag, ".serve_1cyc"}, 8'(bus.serve), 8'd0);
    chk({tag, ".ben_hold"},   8'(bus.ball_enable), 8'd1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    resetn           = 1'b0;
    bus.vsync        = 1'b0;
    bus.start        = 1'b0;
    bus.player_point = 1'b0;
    bus.ai_point     = 1'b0;
    repeat (3) step();
    chk_all_zero("reset");
    resetn = 1'b1;
    repeat (2) step();

    // IDLE ignores points and ticks
    pulse_points(1'b1, 1'b0);
    frame_tick();
    chk_all_zero("idle");

    // Start then first serve
    pulse_start();
    chk("start.ben", 8'(bus.ball_enable), 8'd0);
    serve_sequence("serve0");
    chk("serve0.dir", 8'(bus.serve_dir), 8'd0);
    chk("serve0.ps", 8'(bus.player_score), 8'd0);
    chk("serve0.as", 8'(bus.ai_score), 8'd0);

    // Player point: flash player digit 0,0,1 then serve clears it
    pulse_points(1'b1, 1'b0);
    chk("pp.ps",  8'(bus.player_score), 8'd1);
    chk("pp.ben", 8'(bus.ball_enable), 8'd0);
    chk("pp.dir", 8'(bus.serve_dir), 8'd1);
    chk("pp.bp0", 8'(bus.blank_player), 8'd0);
    frame_tick();
    chk("pp.bp1", 8'(snap_bp), 8'd0);
    chk("pp.ba1", 8'(snap_ba), 8'd0);
    chk("pp.serve1", 8'(snap_serve), 8'd0);
    frame_tick();
    chk("pp.bp2", 8'(snap_bp), 8'd1);
    chk("pp.bp2_hold", 8'(bus.blank_player), 8'd1);
    chk("pp.ba2", 8'(snap_ba), 8'd0);
    chk("pp.serve2", 8'(snap_serve), 8'd0);
    frame_tick();
    chk("pp.serve3", 8'(snap_serve), 8'd1);
    chk("pp.bp3", 8'(snap_bp), 8'd0);
    chk("pp.serve_1cyc", 8'(bus.serve), 8'd0);

    // Simultaneous points: no score change, no flash
    pulse_points(1'b1, 1'b1);
    chk("both.ps",  8'(bus.player_score), 8'd1);
    chk("both.as",  8'(bus.ai_score), 8'd0);
    chk("both.ben", 8'(bus.ball_enable), 8'd0);
    chk("both.dir", 8'(bus.serve_dir), 8'd1);

    // vsync held high counts once; points/start in SERVE_WAIT ignored
    bus.vsync = 1'b1;
    repeat (10) begin
      step();
      chk("hold.serve", 8'(bus.serve), 8'd0);
    end
    bus.vsync = 1'b0;
    step();
    pulse_points(1'b1, 1'b0);
    pulse_points(1'b0, 1'b1);
    pulse_start();
    chk("sw.ps", 8'(bus.player_score), 8'd1);
    chk("sw.as", 8'(bus.ai_score), 8'd0);
    chk("sw.blanks", {6'd0, bus.blank_player, bus.blank_ai}, 8'd0);
    frame_tick();
    chk("hold.t2_serve", 8'(snap_serve), 8'd0);
    frame_tick();
    chk("hold.t3_serve", 8'(snap_serve), 8'd1);

    // AI wins 3-1
    pulse_points(1'b0, 1'b1);
    chk("ai1.as",  8'(bus.ai_score), 8'd1);
    chk("ai1.dir", 8'(bus.serve_dir), 8'd0);
    serve_sequence("ai1");
    pulse_points(1'b0, 1'b1);
    chk("ai2.as", 8'(bus.ai_score), 8'd2);
    serve_sequence("ai2");
    pulse_points(1'b0, 1'b1);
    chk("go.as",     8'(bus.ai_score), 8'd3);
    chk("go.ps",     8'(bus.player_score), 8'd1);
    chk("go.flag",   8'(bus.game_over), 8'd1);
    chk("go.winner", 8'(bus.winner), 8'd0);
    chk("go.ben",    8'(bus.ball_enable), 8'd0);
    chk("go.ba0",    8'(bus.blank_ai), 8'd0);
    begin
      logic [5:0] exp_ba;
      exp_ba = 6'b100110;  // bit k = blank_ai after tick k+1: 0,1,1,0,0,1
      for (int k = 0; k < 6; k++) begin
        frame_tick();
        chk($sformatf("go.ba_t%0d", k + 1), 8'(bus.blank_ai), 8'(exp_ba[k]));
        chk($sformatf("go.bp_t%0d", k + 1), 8'(bus.blank_player), 8'd0);
      end
    end
    pulse_points(1'b1, 1'b0);
    pulse_points(1'b0, 1'b1);
    chk("go.ign_ps", 8'(bus.player_score), 8'd1);
    chk("go.ign_as", 8'(bus.ai_score), 8'd3);
    chk("go.ign_go", 8'(bus.game_over), 8'd1);
    pulse_start();
    chk("restart.ps", 8'(bus.player_score), 8'd0);
    chk("restart.as", 8'(bus.ai_score), 8'd0);
    chk("restart.go", 8'(bus.game_over), 8'd0);
    chk("restart.blanks", {6'd0, bus.blank_player, bus.blank_ai}, 8'd0);

    // Reset mid SERVE_WAIT while flashing
    serve_sequence("rst_pre");
    pulse_points(1'b1, 1'b0);
    frame_tick();
    frame_tick();
    chk("rst_pre.bp", 8'(bus.blank_player), 8'd1);
    resetn = 1'b0;
    #1;
    chk_all_zero("rst_async");
    step();
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      frame_tick();
      chk($sformatf("rst_idle.serve%0d", k), 8'(snap_serve), 8'd0);
    end
    chk_all_zero("rst_idle");
    pulse_start();
    serve_sequence("rst_post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
